// File: rtl/bus_generator_arbiter_pkg.sv
// Shared types and constants for the bus generator arbiter.
// Holds the per-bus FSM state encoding, destination ID width and default broadcast ID.
// No logic lives here; every other file imports this package.
package bus_generator_arbiter_pkg;

    // Destination ID occupies the top ID_W bits of every packet
    localparam int ID_W = 8;

    // Destination ID that addresses every driver except the sender
    localparam logic [ID_W-1:0] BCAST_DEFAULT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } lane_state_t;

endpackage

// File: rtl/bus_generator_arbiter_if.sv
// Driver-side bundle: source FIFO status/data in, dequeue/enqueue strobes and data out.
// master = arbiter side, slave = driver FIFOs side.
// Data buses keep the packet bit as the outermost packed dimension.
interface bus_generator_arbiter_if #(
    parameter int bits    = 1,
    parameter int drvrs   = 4,
    parameter int pckg_sz = 16
);
    logic [bits-1:0][drvrs-1:0]              pndng;
    logic [bits-1:0][drvrs-1:0]              pop;
    logic [bits-1:0][drvrs-1:0]              push;
    logic [pckg_sz-1:0][bits-1:0][drvrs-1:0] D_pop;
    logic [pckg_sz-1:0][bits-1:0][drvrs-1:0] D_push;

    modport master (
        input  pndng,
        input  D_pop,
        output pop,
        output push,
        output D_push
    );

    modport slave (
        output pndng,
        output D_pop,
        input  pop,
        input  push,
        input  D_push
    );
endinterface

// File: rtl/bus_generator_arbiter_bus_lane.sv
// One bus: round-robin grant, pop the winner, push the packet to its destination(s).
// Latency: grant in IDLE, pop next cycle, push the cycle after; one packet per 3 cycles.
// No backpressure: sink FIFOs are assumed to always accept; pndng is only sampled in IDLE.
module bus_lane
    import bus_generator_arbiter_pkg::*;
#(
    parameter int               drvrs     = 4,
    parameter int               pckg_sz   = 16,
    parameter logic [ID_W-1:0]  broadcast = BCAST_DEFAULT
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [drvrs-1:0]                 pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]    d_pop,
    output logic [drvrs-1:0]                 pop,
    output logic [drvrs-1:0]                 push,
    output logic [drvrs-1:0][pckg_sz-1:0]    d_push
);
    localparam int GW = (drvrs > 1) ? $clog2(drvrs) : 1;

    lane_state_t        state, state_nxt;
    logic [GW-1:0]      grant;
    logic [GW-1:0]      start;
    logic [GW-1:0]      pick;
    logic [GW-1:0]      idx;
    logic               found;
    logic [pckg_sz-1:0] data;
    logic [ID_W-1:0]    dest;

    assign dest = data[pckg_sz-1 -: ID_W];

    // Round-robin search: first pending driver at or after the start pointer
    always_comb begin
        found = 1'b0;
        pick  = start;
        idx   = start;
        for (int i = 0; i < drvrs; i++) begin
            idx = GW'((int'(start) + i) % drvrs);
            if (!found && pndng[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant/pointer capture in IDLE, packet capture at the end of POP
    always_ff @(posedge clk) begin
        if (reset) begin
            grant <= '0;
            start <= '0;
            data  <= '0;
        end else begin
            if (state == IDLE && found) begin
                grant <= pick;
                start <= (int'(pick) == drvrs - 1) ? '0 : pick + GW'(1);
            end
            if (state == POP) begin
                data <= d_pop[grant];
            end
        end
    end

    // Next state and strobes; reset kills strobes in the same cycle so an aborted packet never lands
    always_comb begin
        state_nxt = state;
        pop       = '0;
        push      = '0;
        case (state)
            IDLE: begin
                if (found) state_nxt = POP;
            end
            POP: begin
                pop[grant] = 1'b1;
                state_nxt  = PUSH;
            end
            PUSH: begin
                state_nxt = IDLE;
                if (dest == broadcast) begin
                    push        = '1;
                    push[grant] = 1'b0;
                end else if (int'(dest) < drvrs) begin
                    push[dest[GW-1:0]] = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (reset) begin
            pop  = '0;
            push = '0;
        end
    end

    // Every sink sees the latched packet; it holds between transfers
    always_comb begin
        for (int d = 0; d < drvrs; d++) begin
            d_push[d] = data;
        end
    end

endmodule

// File: rtl/bus_generator_arbiter.sv
// Top: bits independent bus lanes, each arbitrating drvrs source FIFOs onto drvrs sinks.
// Latency: pop one cycle after grant, push one cycle after pop, per bus.
// No backpressure on the sink side; sources are throttled only by pndng.
module bus_generator_arbiter
    import bus_generator_arbiter_pkg::*;
#(
    parameter int               bits      = 1,
    parameter int               drvrs     = 4,
    parameter int               pckg_sz   = 16,
    parameter logic [ID_W-1:0]  broadcast = BCAST_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    bus_generator_arbiter_if.master bus
);
    logic [bits-1:0][drvrs-1:0]              lane_pop;
    logic [bits-1:0][drvrs-1:0]              lane_push;
    logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] lane_dpop;
    logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] lane_dpush;

    // Reorder packet-bit-outermost buses into per-driver words for the lanes and back
    always_comb begin
        lane_dpop  = '0;
        bus.D_push = '0;
        for (int b = 0; b < bits; b++) begin
            for (int d = 0; d < drvrs; d++) begin
                for (int k = 0; k < pckg_sz; k++) begin
                    lane_dpop[b][d][k]  = bus.D_pop[k][b][d];
                    bus.D_push[k][b][d] = lane_dpush[b][d][k];
                end
            end
        end
    end

    assign bus.pop  = lane_pop;
    assign bus.push = lane_push;

    for (genvar b = 0; b < bits; b++) begin : g_lane
        bus_lane #(
            .drvrs     (drvrs),
            .pckg_sz   (pckg_sz),
            .broadcast (broadcast)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .pndng  (bus.pndng[b]),
            .d_pop  (lane_dpop[b]),
            .pop    (lane_pop[b]),
            .push   (lane_push[b]),
            .d_push (lane_dpush[b])
        );
    end

endmodule

// File: tb/tb_bus_generator_arbiter.sv
// Bench for bus_generator_arbiter: one bus, four drivers fed from bench-side FIFOs.
// A transaction-level model predicts pop/push/D_push every cycle.
// Directed packets first, then random traffic with occasional resets.
module tb_bus_generator_arbiter;
    localparam int NB = 1;
    localparam int ND = 4;
    localparam int PW = 16;

    logic clk;
    logic reset;

    bus_generator_arbiter_if #(.bits(NB), .drvrs(ND), .pckg_sz(PW)) bus ();

    bus_generator_arbiter #(
        .bits      (NB),
        .drvrs     (ND),
        .pckg_sz   (PW),
        .broadcast (8'hFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Driver source FIFOs and what was presented to the DUT this cycle
    logic [PW-1:0] q [ND][$];
    logic [PW-1:0] head_drv [ND];
    logic [ND-1:0] pn_drv;
    logic          rst_next;

    // Reference model state
    int            sched_pop;   // driver expected to pop this cycle, -1 if none
    bit            push_valid;  // this cycle is a push cycle
    logic [PW-1:0] push_pkt;
    int            push_src;
    int            ptr;         // next driver to search first
    logic [PW-1:0] dpush_exp;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, want %h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [ND-1:0] route(input logic [PW-1:0] pkt, input int src);
        logic [7:0]    dst;
        logic [ND-1:0] m;
        dst = pkt[PW-1:PW-8];
        m   = '0;
        if (dst == 8'hFF) begin
            m      = '1;
            m[src] = 1'b0;
        end else if (int'(dst) < ND) begin
            m[int'(dst)] = 1'b1;
        end
        return m;
    endfunction

    task automatic model_reset();
        sched_pop  = -1;
        push_valid = 1'b0;
        push_pkt   = '0;
        push_src   = 0;
        ptr        = 0;
        dpush_exp  = '0;
    endtask

    // One clock: drive after the edge, check and advance the model at the falling edge
    task automatic cycle();
        logic [ND-1:0] exp_pop, exp_push;
        logic [63:0]   obs_dp, exp_dp;
        bit            idle;
        int            nxt;
        @(posedge clk);
        #1;
        reset = rst_next;
        for (int d = 0; d < ND; d++) begin
            pn_drv[d]   = (q[d].size() != 0);
            head_drv[d] = pn_drv[d] ? q[d][0] : '0;
            for (int k = 0; k < PW; k++) bus.D_pop[k][0][d] = head_drv[d][k];
        end
        bus.pndng[0] = pn_drv;
        @(negedge clk);

        exp_pop  = '0;
        exp_push = '0;
        if (!reset && sched_pop >= 0) exp_pop[sched_pop] = 1'b1;
        if (!reset && push_valid)     exp_push = route(push_pkt, push_src);
        check("pop",  64'(bus.pop[0]),  64'(exp_pop));
        check("push", 64'(bus.push[0]), 64'(exp_push));
        if (!reset) begin
            obs_dp = '0;
            exp_dp = '0;
            for (int d = 0; d < ND; d++) begin
                for (int k = 0; k < PW; k++) obs_dp[d*PW+k] = bus.D_push[k][0][d];
                exp_dp[d*PW +: PW] = dpush_exp;
            end
            check("D_push", obs_dp, exp_dp);
        end

        if (reset) begin
            model_reset();
        end else begin
            idle = (sched_pop < 0) && !push_valid;
            if (sched_pop >= 0) begin
                push_valid = 1'b1;
                push_pkt   = head_drv[sched_pop];
                push_src   = sched_pop;
                dpush_exp  = head_drv[sched_pop];
            end else begin
                push_valid = 1'b0;
            end
            nxt = -1;
            if (idle) begin
                for (int i = 0; i < ND; i++) begin
                    if (nxt < 0 && pn_drv[(ptr + i) % ND]) nxt = (ptr + i) % ND;
                end
                if (nxt >= 0) ptr = (nxt + 1) % ND;
            end
            sched_pop = nxt;
        end

        // Source FIFOs dequeue on the DUT's own strobe
        for (int d = 0; d < ND; d++) begin
            if (bus.pop[0][d] && q[d].size() != 0) void'(q[d].pop_front());
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset(input int n);
        rst_next = 1'b1;
        run(n);
        rst_next = 1'b0;
    endtask

    initial begin
        logic [PW-1:0] pkt;
        int            d, r;
        reset        = 1'b1;
        rst_next     = 1'b1;
        bus.pndng    = '0;
        bus.D_pop    = '0;
        pn_drv       = '0;
        model_reset();
        for (int i = 0; i < ND; i++) head_drv[i] = '0;

        do_reset(3);
        run(2);

        // Unicast from driver 1 to driver 2
        q[1].push_back(16'h02A5);
        run(5);

        // Broadcast from driver 0
        q[0].push_back(16'hFF3C);
        run(5);

        // All drivers pending from a fresh pointer: 0,1,2,3,0
        do_reset(1);
        q[0].push_back(16'h0111); q[0].push_back(16'h0222);
        q[1].push_back(16'h00AA);
        q[2].push_back(16'hFF5A);
        q[3].push_back(16'h0133);
        run(18);

        // Destination beyond the driver count is dropped
        q[2].push_back(16'h0711);
        run(5);

        // Reset in the push cycle discards the packet; driver 0 first afterwards
        q[1].push_back(16'h0301);
        for (int i = 0; i < 10 && !push_valid; i++) cycle();
        q[0].push_back(16'h0244);
        q[2].push_back(16'h0166);
        do_reset(1);
        run(8);

        // Self-delivery
        q[3].push_back(16'h0355);
        run(5);

        // Random traffic with occasional resets
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                d = $urandom_range(0, ND - 1);
                r = $urandom_range(0, 5);
                pkt[7:0] = 8'($urandom);
                if (r == 0)      pkt[15:8] = 8'hFF;
                else if (r <= 4) pkt[15:8] = 8'(r - 1);
                else             pkt[15:8] = 8'($urandom_range(4, 254));
                if (q[d].size() < 8) q[d].push_back(pkt);
            end
            rst_next = ($urandom_range(0, 59) == 0);
            cycle();
        end
        rst_next = 1'b0;
        run(12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
